jtdsp16_do_ctl: RTL and testbench

- Do-loop sequencer sitting directly upstream of the ROM address arithmetic unit (XAAU).
- Decodes "do K {N instr}" and "redo K" requests from the instruction decoder.
- Drives the XAAU's do-loop controls: do_start, do_redo, do_save, do_out, do_short, do_pc, pc_halt.
- Counts instruction slots (N, 1..15) and iterations (K, 1..127) so the XAAU can replay the block from do_head + do_pc.

---
 rtl/jtdsp16_do_pkg.sv | 24 ++
 rtl/jtdsp16_do_ctl.sv | 161 ++++++++++++++++
 tb/tb_jtdsp16_do_ctl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtdsp16_do_pkg.sv
// +--------------------------------------------------------------------------+
// | jtdsp16_do_pkg : shared encodings for the do-loop sequencer              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package jtdsp16_do_pkg;

  localparam int NW    = 4;
  localparam int KW    = 7;

  localparam int N_MSB = 10;
  localparam int N_LSB = 7;
  localparam int K_MSB = 6;
  localparam int K_LSB = 0;

  typedef logic [0:0] state_t;

  localparam state_t S_IDLE = 1'b0;
  localparam state_t S_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/jtdsp16_do_ctl.sv
// +--------------------------------------------------------------------------+
// | jtdsp16_do_ctl : "do K {N instr}" / "redo K" sequencer feeding the XAAU  |
// | Optional debug outputs when JTDSP16_DO_DEBUG_EN is defined. Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module jtdsp16_do_ctl
  import jtdsp16_do_pkg::*;
#(
  parameter int NW_P = NW,
  parameter int KW_P = KW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              do_en,
  input  logic              redo_en,
  input  logic [10:0]       do_data,
  input  logic              irq_pend,
  output logic              do_start,
  output logic              do_redo,
  output logic              do_save,
  output logic              do_short,
  output logic              do_out,
  output logic [NW_P-1:0]   do_pc,
  output logic              pc_halt,
  output logic              busy,
`ifdef JTDSP16_DO_DEBUG_EN
  output logic [NW_P-1:0]   debug_n,
  output logic [KW_P-1:0]   debug_k,
  output logic [KW_P-1:0]   debug_iter,
`endif
  output logic              do_err
);

  state_t            state_q, state_d;
  logic [NW_P-1:0]   n_q, n_d;
  logic [KW_P-1:0]   k_q, k_d;
  logic [NW_P-1:0]   pc_q, pc_d;
  logic              err_q, err_d;
`ifdef JTDSP16_DO_DEBUG_EN
  logic [KW_P-1:0]   iter_q, iter_d;
`endif

  logic [NW_P-1:0]   w_n;
  logic [KW_P-1:0]   w_k;
  logic              w_do_acc;
  logic              w_redo_acc;
  logic              w_last_slot;
  logic              w_last_iter;
  logic              w_unused_irq;

  // Interrupts are held off by the XAAU while in cache; nothing to do here.
  assign w_unused_irq = irq_pend;

  assign w_n         = do_data[N_MSB:N_LSB];
  assign w_k         = do_data[K_MSB:K_LSB];
  assign w_do_acc    = do_en && (w_n != '0) && (w_k != '0);
  assign w_redo_acc  = !do_en && redo_en && (n_q != '0) && (w_k != '0);
  assign w_last_slot = (pc_q == n_q - NW_P'(1));
  assign w_last_iter = (k_q == KW_P'(1));

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
`ifdef JTDSP16_DO_DEBUG_EN
      iter_q  <= '0;
`endif
    end else if (cen) begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
`ifdef JTDSP16_DO_DEBUG_EN
      iter_q  <= iter_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    pc_d    = pc_q;
    err_d   = err_q;
`ifdef JTDSP16_DO_DEBUG_EN
    iter_d  = iter_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_do_acc || w_redo_acc) begin
          if (w_do_acc) n_d = w_n;
          k_d     = w_k;
          pc_d    = '0;
          state_d = S_RUN;
`ifdef JTDSP16_DO_DEBUG_EN
          iter_d  = '0;
`endif
        end
      end
      S_RUN: begin
        if (do_en || redo_en) err_d = 1'b1;
        if (w_last_slot) begin
          pc_d = '0;
          k_d  = k_q - KW_P'(1);
`ifdef JTDSP16_DO_DEBUG_EN
          iter_d = iter_q + KW_P'(1);
`endif
          if (w_last_iter) state_d = S_IDLE;
        end else begin
          pc_d = pc_q + NW_P'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    do_start = 1'b0;
    do_redo  = 1'b0;
    do_save  = 1'b0;
    do_short = 1'b0;
    do_out   = 1'b0;
    pc_halt  = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        do_start = w_do_acc || w_redo_acc;
        do_save  = w_do_acc;
        do_redo  = w_redo_acc;
      end
      S_RUN: begin
        busy     = 1'b1;
        pc_halt  = 1'b1;
        do_short = (n_q == NW_P'(1));
        do_out   = w_last_slot && w_last_iter;
      end
      default: ;
    endcase
  end

  assign do_pc  = pc_q;
  assign do_err = err_q;

`ifdef JTDSP16_DO_DEBUG_EN
  assign debug_n    = n_q;
  assign debug_k    = k_q;
  assign debug_iter = iter_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jtdsp16_do_ctl.sv
// Directed self-checking bench for jtdsp16_do_ctl: loop entry, short loops,
// redo, rejected requests, nested-request error, clock enable and reset.
`default_nettype none

module tb_jtdsp16_do_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic        do_en = 1'b0;
  logic        redo_en = 1'b0;
  logic [10:0] do_data = '0;
  logic        irq_pend = 1'b0;
  logic        do_start, do_redo, do_save, do_short, do_out, pc_halt, busy, do_err;
  logic [3:0]  do_pc;
`ifdef JTDSP16_DO_DEBUG_EN
  logic [3:0]  debug_n;
  logic [6:0]  debug_k;
  logic [6:0]  debug_iter;
`endif

  int checks = 0;
  int errors = 0;

  jtdsp16_do_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .do_en      (do_en),
    .redo_en    (redo_en),
    .do_data    (do_data),
    .irq_pend   (irq_pend),
    .do_start   (do_start),
    .do_redo    (do_redo),
    .do_save    (do_save),
    .do_short   (do_short),
    .do_out     (do_out),
    .do_pc      (do_pc),
    .pc_halt    (pc_halt),
    .busy       (busy),
`ifdef JTDSP16_DO_DEBUG_EN
    .debug_n    (debug_n),
    .debug_k    (debug_k),
    .debug_iter (debug_iter),
`endif
    .do_err     (do_err)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst = 1'b1;
    @(negedge clk);
    got = {do_start, do_redo, do_save, do_short, do_out, pc_halt, busy, do_err, do_pc};
    checks++;
    if (got !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", got, 12'h000);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_do_basic();
    logic [7:0] got, exp;
    next_cycle();
    do_en = 1'b1; do_data = {4'd3, 7'd2};
    @(negedge clk);
    checks++;
    if ({do_start, do_save, do_redo, busy} !== 4'b1100) begin
      errors++;
      $display("FAIL do_entry_strobes: got %b expected 1100", {do_start, do_save, do_redo, busy});
    end
    next_cycle();
    do_en = 1'b0; do_data = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got = {busy, pc_halt, do_out, do_short, do_pc};
      exp = {1'b1, 1'b1, (i == 5), 1'b0, 4'(i % 3)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_run_cycle%0d: got %b expected %b", i, got, exp);
      end
      next_cycle();
    end
    @(negedge clk);
    got = {busy, pc_halt, do_out, do_short, do_pc};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL basic_after_loop: got %b expected %b", got, 8'h00);
    end
  endtask

  task automatic test_short();
    logic [7:0] got, exp;
    int halts = 0;
    next_cycle();
    do_en = 1'b1; do_data = {4'd1, 7'd5};
    next_cycle();
    do_en = 1'b0; do_data = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (pc_halt) halts++;
      got = {busy, pc_halt, do_out, do_short, do_pc};
      exp = (i < 5) ? {1'b1, 1'b1, (i == 4), 1'b1, 4'd0} : 8'h00;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL short_cycle%0d: got %b expected %b", i, got, exp);
      end
      next_cycle();
    end
    checks++;
    if (halts != 5) begin
      errors++;
      $display("FAIL short_halt_count: got %0d expected 5", halts);
    end
  endtask

  task automatic test_redo();
    logic [7:0] got, exp;
    redo_en = 1'b1; do_data = {4'd0, 7'd3};
    @(negedge clk);
    checks++;
    if ({do_start, do_redo, do_save} !== 3'b110) begin
      errors++;
      $display("FAIL redo_strobes: got %b expected 110", {do_start, do_redo, do_save});
    end
    next_cycle();
    redo_en = 1'b0; do_data = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = {busy, pc_halt, do_out, do_short, do_pc};
      exp = (i < 3) ? {1'b1, 1'b1, (i == 2), 1'b1, 4'd0} : 8'h00;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL redo_cycle%0d: got %b expected %b", i, got, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_ignored();
    logic [10:0] bad [2];
    bad[0] = {4'd0, 7'd5};
    bad[1] = {4'd2, 7'd0};
    for (int i = 0; i < 2; i++) begin
      do_en = 1'b1; do_data = bad[i];
      @(negedge clk);
      checks++;
      if ({do_start, do_save, do_redo} !== 3'b000) begin
        errors++;
        $display("FAIL ignored_do%0d_strobes: got %b expected 000", i, {do_start, do_save, do_redo});
      end
      next_cycle();
      do_en = 1'b0; do_data = '0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL ignored_do%0d_busy: got %b expected 0", i, busy);
      end
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    redo_en = 1'b1; do_data = {4'd2, 7'd3};
    @(negedge clk);
    checks++;
    if ({do_start, do_redo} !== 2'b00) begin
      errors++;
      $display("FAIL redo_after_reset_strobes: got %b expected 00", {do_start, do_redo});
    end
    next_cycle();
    redo_en = 1'b0; do_data = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL redo_after_reset_busy: got %b expected 0", busy);
    end
    next_cycle();
  endtask

  task automatic test_nested_err();
    logic [8:0] got, exp;
    do_en = 1'b1; do_data = {4'd4, 7'd3};
    next_cycle();
    do_en = 1'b0; do_data = '0;
    for (int i = 0; i < 12; i++) begin
      do_en   = (i == 6);
      do_data = (i == 6) ? {4'd1, 7'd1} : 11'd0;
      @(negedge clk);
      got = {busy, pc_halt, do_out, do_err, 1'b0, do_pc};
      exp = {1'b1, 1'b1, (i == 11), (i > 6), 1'b0, 4'(i % 4)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL nested_cycle%0d: got %b expected %b", i, got, exp);
      end
      next_cycle();
    end
    do_en = 1'b0; do_data = '0;
    @(negedge clk);
    checks++;
    if ({busy, do_err} !== 2'b01) begin
      errors++;
      $display("FAIL nested_after_loop: got %b expected 01", {busy, do_err});
    end
  endtask

  task automatic test_cen_rst();
    logic [7:0]  got, exp;
    logic [11:0] all;
    int cnt = 0;
    next_cycle();
    do_en = 1'b1; do_data = {4'd2, 7'd2};
    next_cycle();
    do_en = 1'b0; do_data = '0;
    for (int j = 0; j < 8; j++) begin
      cen = (j % 2 == 1);
      @(negedge clk);
      got = {busy, pc_halt, do_out, do_short, do_pc};
      exp = {1'b1, 1'b1, (cnt == 3), 1'b0, 4'(cnt % 2)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cen_cycle%0d: got %b expected %b", j, got, exp);
      end
      if (cen) cnt++;
      next_cycle();
    end
    cen = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cen_after_loop: got %b expected 0", busy);
    end
    next_cycle();
    do_en = 1'b1; do_data = {4'd2, 7'd2};
    next_cycle();
    do_en = 1'b0; do_data = '0;
    next_cycle();
    rst = 1'b1;
    #1;
    all = {do_start, do_redo, do_save, do_short, do_out, pc_halt, busy, do_err, do_pc};
    checks++;
    if (all !== 12'h000) begin
      errors++;
      $display("FAIL midloop_reset: got %b expected %b", all, 12'h000);
    end
    next_cycle();
    rst = 1'b0;
    redo_en = 1'b1; do_data = {4'd0, 7'd2};
    @(negedge clk);
    checks++;
    if ({do_start, do_redo} !== 2'b00) begin
      errors++;
      $display("FAIL redo_after_midloop_reset: got %b expected 00", {do_start, do_redo});
    end
    next_cycle();
    redo_en = 1'b0; do_data = '0;
  endtask

  initial begin
    test_reset();
    test_do_basic();
    test_short();
    test_redo();
    test_ignored();
    test_nested_err();
    test_cen_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
